// File: rtl/syndrome_scale_gen.sv
// rtl/syndrome_scale_gen.sv - scales the stored syndrome vector S by each selected f scalar over GF(2^m)
// Optional build macro SCALE_ONE_BYPASS_EN: skip the multipliers when the scalar is the field element 1.

module gf2m_mul #(
    parameter int m = 79,
    parameter logic [m-1:0] POLY = m'(513),
    parameter int DELAY = 6
) (
    input  logic         clk,
    input  logic         rst_b,
    input  logic         start,
    input  logic [m-1:0] a,
    input  logic [m-1:0] b,
    output logic         done,
    output logic [m-1:0] result
);
    logic [DELAY-1:0] pipe;

    // MSB-first interleaved multiply and reduce; the product is held until the next start
    function automatic logic [m-1:0] gf_mul(input logic [m-1:0] x, input logic [m-1:0] y);
        logic [m-1:0] r;
        r = '0;
        for (int i = m - 1; i >= 0; i--) begin
            r = {r[m-2:0], 1'b0} ^ (r[m-1] ? POLY : '0);
            if (y[i]) r = r ^ x;
        end
        return r;
    endfunction

    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            pipe   <= '0;
            result <= '0;
        end else begin
            pipe <= (pipe << 1) | DELAY'(start);
            if (start) result <= gf_mul(a, b);
        end
    end

    assign done = pipe[DELAY-1];
endmodule

module syndrome_scale_gen #(
    parameter int n = 47,
    parameter int m = 79,
    parameter int d = 5,
    parameter int P = 1,
    parameter int NF = 2,
    parameter int DELAY_mul = 6,
    parameter int DELAY_rd = 1,
    parameter int DEPTH = (n + d - 1) / d,
    parameter int OG = (n + P - 1) / P,
    parameter int AW_OUT = $clog2(NF * OG + OG),
    parameter logic [m-1:0] POLY = m'(513)
) (
    input  logic                        clk,
    input  logic                        rst_b,
    input  logic                        start,
    input  logic [$clog2(NF+1)-1:0]     f_first,
    input  logic [$clog2(NF+1)-1:0]     f_count,
    input  logic [AW_OUT-1:0]           out_base,
    output logic                        busy,
    output logic                        finish,
    input  logic [m*d-1:0]              S_din,
    output logic [$clog2(DEPTH)-1:0]    S_addr,
    input  logic [m-1:0]                f_din,
    output logic [$clog2(NF+1)-1:0]     f_addr,
    output logic [P*m-1:0]              out_dout,
    output logic [AW_OUT-1:0]           out_addr,
    output logic                        out_we,
    output logic [P-1:0]                out_mask
);
    localparam int FW  = $clog2(NF + 1);
    localparam int RW  = $clog2(DEPTH);
    localparam int GPR = d / P;
    localparam int GW  = (GPR > 1) ? $clog2(GPR) : 1;
    localparam int CW  = (DELAY_rd > 0) ? $clog2(DELAY_rd + 1) : 1;

    typedef enum logic [2:0] {IDLE, FETCH, MUL, WAIT, WRITE, DONE} state_t;
    state_t state;

    logic [FW-1:0]     j, ff_q, fc_q;
    logic [RW-1:0]     row;
    logic [GW-1:0]     grp;
    logic [CW-1:0]     cnt;
    logic [AW_OUT-1:0] base_q;
    logic [m-1:0]      f_reg;
    logic [m*d-1:0]    row_reg;
    logic              byp;

    logic [m-1:0]      op  [P];
    logic [m-1:0]      res [P];
    logic [P-1:0]      done_v;
    logic              mul_start, mul_done, bypass_now, grp_more;
    logic [P*m-1:0]    wr_data;
    logic [P-1:0]      wr_mask;
    logic [AW_OUT-1:0] wr_addr;
    int                base_idx;

`ifdef SCALE_ONE_BYPASS_EN
    assign bypass_now = (f_reg == m'(1));
`else
    assign bypass_now = 1'b0;
`endif

    assign mul_start = (state == MUL) && !bypass_now;
    assign mul_done  = &done_v;

    // The current group always sits in the top P elements of the row register
    for (genvar i = 0; i < P; i++) begin : g_lane
        assign op[i] = row_reg[m*d-1-i*m -: m];
        gf2m_mul #(.m(m), .POLY(POLY), .DELAY(DELAY_mul)) u_mul (
            .clk    (clk),
            .rst_b  (rst_b),
            .start  (mul_start),
            .a      (op[i]),
            .b      (f_reg),
            .done   (done_v[i]),
            .result (res[i])
        );
    end

    always_comb begin
        base_idx = int'(row) * d + int'(grp) * P;
        wr_data  = '0;
        wr_mask  = '0;
        for (int i = 0; i < P; i++) begin
            if (base_idx + i < n) begin
                wr_mask[P-1-i]          = 1'b1;
                wr_data[P*m-1-i*m -: m] = byp ? op[i] : res[i];
            end
        end
        grp_more = (int'(grp) + 1 < GPR) && (base_idx + P < n);
        wr_addr  = AW_OUT'(int'(base_q) + int'(j) * OG + int'(row) * GPR + int'(grp));
    end

    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            state    <= IDLE;
            busy     <= 1'b0;
            finish   <= 1'b0;
            out_we   <= 1'b0;
            out_mask <= '0;
            out_dout <= '0;
            out_addr <= '0;
            S_addr   <= '0;
            f_addr   <= '0;
            j        <= '0;
            row      <= '0;
            grp      <= '0;
            cnt      <= '0;
            ff_q     <= '0;
            fc_q     <= '0;
            base_q   <= '0;
            f_reg    <= '0;
            row_reg  <= '0;
            byp      <= 1'b0;
        end else begin
            finish   <= 1'b0;
            out_we   <= 1'b0;
            out_mask <= '0;
            out_dout <= '0;
            case (state)
                IDLE: if (start) begin
                    busy   <= 1'b1;
                    ff_q   <= f_first;
                    fc_q   <= f_count;
                    base_q <= out_base;
                    j      <= '0;
                    row    <= '0;
                    grp    <= '0;
                    cnt    <= '0;
                    if (f_count == '0) begin
                        state <= DONE;
                    end else begin
                        f_addr <= f_first;
                        S_addr <= '0;
                        state  <= FETCH;
                    end
                end
                FETCH: if (cnt == CW'(DELAY_rd)) begin
                    cnt     <= '0;
                    f_reg   <= f_din;
                    row_reg <= S_din;
                    state   <= MUL;
                end else begin
                    cnt <= cnt + CW'(1);
                end
                MUL: begin
                    byp   <= bypass_now;
                    state <= bypass_now ? WRITE : WAIT;
                end
                WAIT: if (mul_done) state <= WRITE;
                WRITE: begin
                    out_we   <= 1'b1;
                    out_dout <= wr_data;
                    out_mask <= wr_mask;
                    out_addr <= wr_addr;
                    if (grp_more) begin
                        grp     <= grp + GW'(1);
                        row_reg <= row_reg << (P * m);
                        state   <= MUL;
                    end else if (int'(row) < DEPTH - 1) begin
                        row    <= row + RW'(1);
                        grp    <= '0;
                        S_addr <= row + RW'(1);
                        f_addr <= ff_q + j;
                        state  <= FETCH;
                    end else if (int'(j) + 1 < int'(fc_q)) begin
                        j      <= j + FW'(1);
                        row    <= '0;
                        grp    <= '0;
                        S_addr <= '0;
                        f_addr <= ff_q + j + FW'(1);
                        state  <= FETCH;
                    end else begin
                        state <= DONE;
                    end
                end
                DONE: begin
                    finish <= 1'b1;
                    busy   <= 1'b0;
                    state  <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: doc/syndrome_scale_gen.md
Name: syndrome_scale_gen

Overview:
- Parametrised successor of the S1/S2 generator in ROLLO decrypt.
- On `start`, for each of NF scalars f_j (j=0..NF-1) read from the f memory, computes C_j = f_j * S over GF(2^m) for all n syndrome elements stored d-per-row in memory S.
- Results are written to the S-scaled memory, P elements per write.
- Uses P parallel gf2m_mul instances; the f index range and the output base address are runtime inputs.
- Covers both the S1/S2 pass and the later Si passes.

Parameters:
n, 47, number of GF(2^m) elements in S
m, 79, field degree
d, 5, elements per S memory row
P, 1, parallel multipliers; must divide d
NF, 2, maximum scalars processed per start
DELAY_mul, 6, cycles from multiplier start to done
DELAY_rd, 1, memory read latency (S and f)
DEPTH, ceil(n/d), rows of S
OG, ceil(n/P), output words per scalar
AW_OUT, clog2(NF*OG+OG), output address width

Ports:
clk  in  1  clock
rst_b  in  1  asynchronous active-low reset
start  in  1  single-cycle start; ignored while busy
f_first  in  clog2(NF+1)  first f memory address used
f_count  in  clog2(NF+1)  number of scalars to process, 1..NF (0 -> immediate finish)
out_base  in  AW_OUT  output base word address
busy  out  1  high from the cycle after an accepted start until finish
finish  out  1  one-cycle pulse when the last write has been issued
S_din  in  m*d  S row read data, element 0 in the MSBs
S_addr  out  clog2(DEPTH)  S row address
f_din  in  m  scalar read data
f_addr  out  clog2(NF+1)  f memory address
out_dout  out  P*m  result word, lane 0 in the MSBs
out_addr  out  AW_OUT  result word address
out_we  out  1  write strobe
out_mask  out  P  per-lane valid mask, bit P-1 = lane 0

Behaviour:
- Reset (asynchronous, rst_b low): state IDLE; busy, finish, out_we = 0; out_mask, out_dout, S_addr, f_addr, out_addr = 0; all counters 0.
- Reset asserted mid-operation aborts immediately. No partial finish is issued.
- start is sampled in IDLE only. f_first, f_count and out_base are latched on the accepted start.
- State IDLE:
  - start with f_count=0 -> DONE.
  - start with f_count>0 -> FETCH, with j=0, row=0, grp=0.
- State FETCH:
  - Drives f_addr = f_first+j and S_addr = row.
  - Waits DELAY_rd+1 cycles, then registers f_din into f_reg and S_din into the row shift register.
  - -> MUL.
- State MUL (1 cycle):
  - Pulses start to all P multipliers.
  - Operand a of lane i = element grp*P+i of the row; operand b = f_reg.
  - -> WAIT.
- State WAIT: holds until lane 0 reports done (all lanes have identical latency).
- State WRITE (1 cycle):
  - out_we=1, out_dout = lane results, out_addr = out_base + j*OG + (row*d/P + grp).
  - out_mask = all ones, except in the last row, where lanes with element index >= n are 0 and their data is 0.
  - Next step, in priority order:
    - grp+1 < d/P and the next group holds valid elements -> grp+1, shift the row register by P*m, -> MUL.
    - row < DEPTH-1 -> row+1, grp=0, -> FETCH.
    - j+1 < f_count -> j+1, row=0, grp=0, -> FETCH.
    - otherwise -> DONE.
- State DONE: finish=1 for one cycle, busy=0 -> IDLE.
- out_we, out_mask and out_dout are 0 in every state except WRITE.
- Per-group cost is DELAY_mul+2 cycles. Each row adds DELAY_rd+1 cycles of FETCH.
- Output addresses are strictly increasing and contiguous within one scalar. Address arithmetic wraps modulo 2^AW_OUT; caller keeps out_base + f_count*OG within range.
- f_first+j beyond NF-1 is not checked.

Optional Feature:
SCALE_ONE_BYPASS_EN:
- Defined: in MUL, if f_reg equals the field element 1 (value 1), skip the multipliers. Go directly to WRITE on the next cycle with out_dout = operand lanes (per-group cost 2 cycles). Masking and addressing are unchanged.
- Undefined: all groups pass through the multipliers; timing is independent of data.

Test Plan:
- n=47, d=5, P=1, f_first=0, f_count=2, out_base=0, random S, f:
  - -> 94 writes, addresses 0..93, each out_mask=1.
  - addr k holds f0*S_k; addr 47+k holds f1*S_k.
  - one finish pulse; busy low afterwards.
- P=5, f_count=1, out_base=30:
  - -> 10 writes at addresses 30..39, masks 11111 except addr 39 = 11000.
  - lanes 2..4 of addr 39 are zero.
- f_count=0 -> finish 2 cycles after start, no out_we, busy returns low.
- start re-pulsed while busy, mid-run -> ignored; write sequence and count identical to a run without the extra pulse.
- rst_b pulled low during WAIT of the 20th group -> all outputs 0 at once, no finish; a fresh start then completes normally.
- SCALE_ONE_BYPASS_EN defined, f=1 -> out_dout equals S; run with P=1, n=47 completes in 47*2 + 10*(DELAY_rd+1) + 2 cycles.
